// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Cleans up the raw Basys3 push-button pads for use by the CPU I/O port and
// control logic. Each channel is independent and passes through:
//   1. a 2-flop synchroniser (sync1 -> sync2)
//   2. a debounce counter that accepts a new level only after
//      DEBOUNCE_CYCLES consecutive samples disagree with the current level
//   3. a repeat FSM that turns a held button into a strobe train:
//      press, then REPEAT_DELAY cycles later, then every REPEAT_RATE cycles.
//
// There is no valid/ready handshake: every output is a plain registered
// level or a single-cycle pulse in the clk domain.
//
// Ports:
//   clk         board clock (100 MHz)
//   rst         asynchronous, active-high reset
//   btn_in      [N] raw button pads, asynchronous, active-high
//   btn_level   [N] debounced level
//   btn_press   [N] one-cycle pulse when the debounced level goes 0->1
//   btn_release [N] one-cycle pulse when the debounced level goes 1->0
//   btn_strobe  [N] press pulse plus auto-repeat pulses while held
//
// The per-channel repeat state (rpt[i].state / rpt[i].cnt) is kept in a
// packed struct so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_strobe
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW      = $clog2(DEBOUNCE_CYCLES);
    localparam int RW      = $clog2(RPT_MAX);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2
    } rpt_state_e;

    typedef struct packed {
        rpt_state_e      state;
        logic [RW-1:0]   cnt;
    } rpt_t;

    // Synchroniser
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;

    // Debounce
    logic [DW-1:0] db_cnt     [N];
    logic [DW-1:0] db_cnt_nxt [N];
    logic [N-1:0]  level_nxt;
    logic [N-1:0]  press_nxt;
    logic [N-1:0]  release_nxt;

    // Repeat FSM
    rpt_t          rpt     [N];
    rpt_t          rpt_nxt [N];
    logic [N-1:0]  strobe_nxt;

    // -------------------------------------------------------------------------
    // Debounce next-state. A level change is accepted on the DEBOUNCE_CYCLES-th
    // consecutive disagreeing sample; any agreeing sample restarts the count.
    // -------------------------------------------------------------------------
    always_comb begin
        db_cnt_nxt  = '{default: '0};
        level_nxt   = btn_level;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (sync2[i] != btn_level[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    level_nxt[i]   = sync2[i];
                    press_nxt[i]   = sync2[i];
                    release_nxt[i] = ~sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Repeat FSM next-state. Decisions are made on the same edge the debounce
    // stage accepts a change, so the strobe lines up with btn_press, and a
    // release takes priority over a strobe due on that same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        rpt_nxt    = rpt;
        strobe_nxt = '0;
        for (int i = 0; i < N; i++) begin
            case (rpt[i].state)
                RELEASED: begin
                    rpt_nxt[i].cnt = '0;
                    if (press_nxt[i]) begin
                        strobe_nxt[i]    = 1'b1;
                        rpt_nxt[i].state = DELAY;
                    end
                end
                DELAY: begin
                    if (release_nxt[i]) begin
                        rpt_nxt[i].state = RELEASED;
                        rpt_nxt[i].cnt   = '0;
                    end else if (rpt[i].cnt == DELAY_LAST) begin
                        strobe_nxt[i]    = 1'b1;
                        rpt_nxt[i].state = REPEAT;
                        rpt_nxt[i].cnt   = '0;
                    end else begin
                        rpt_nxt[i].cnt = rpt[i].cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (release_nxt[i]) begin
                        rpt_nxt[i].state = RELEASED;
                        rpt_nxt[i].cnt   = '0;
                    end else if (rpt[i].cnt == RATE_LAST) begin
                        strobe_nxt[i]  = 1'b1;
                        rpt_nxt[i].cnt = '0;
                    end else begin
                        rpt_nxt[i].cnt = rpt[i].cnt + 1'b1;
                    end
                end
                default: begin
                    rpt_nxt[i].state = RELEASED;
                    rpt_nxt[i].cnt   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_strobe  <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt[i]    <= '0;
                rpt[i].state <= RELEASED;
                rpt[i].cnt   <= '0;
            end
        end else begin
            sync1       <= btn_in;
            sync2       <= sync1;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_strobe  <= strobe_nxt;
            for (int i = 0; i < N; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
                rpt[i]    <= rpt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Bench for btn_conditioner with N=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. A behavioural model derives the expected outputs from the
// button history: a level is accepted once the last DEBOUNCE_CYCLES samples
// seen after the two synchroniser stages all differ from it, and strobes are
// timed arithmetically from the press edge. Directed scenarios pin exact
// edge numbers; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    localparam int KP = 0;
    localparam int KR = 1;
    localparam int KS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_strobe;

    btn_conditioner #(
        .N              (N),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_strobe (btn_strobe)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    int tb_cyc   = 0;
    int errors   = 0;
    int checks   = 0;
    bit check_en = 1'b0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // ---------------------------------------------------------------- checks
    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [N-1:0] samp_q[$];
    logic [N-1:0] obs_q[$];
    logic [N-1:0] m_level, m_press, m_release, m_strobe;
    logic [N-1:0] m_obs;
    int           m_cyc;
    int           press_edge [N];
    int           m_d;
    bit           all_diff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q.delete();
            obs_q.delete();
            m_cyc     = 0;
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            m_strobe  = '0;
            for (int i = 0; i < N; i++) press_edge[i] = 0;
        end else begin
            m_cyc++;
            // The debounce stage sees the pad value from two edges ago,
            // or zero while the synchroniser is still full of reset values.
            samp_q.push_back(btn_in);
            if (samp_q.size() > 3) void'(samp_q.pop_front());
            m_obs = (samp_q.size() == 3) ? samp_q[0] : '0;
            obs_q.push_back(m_obs);
            if (obs_q.size() > DB) void'(obs_q.pop_front());

            m_press   = '0;
            m_release = '0;
            for (int ch = 0; ch < N; ch++) begin
                all_diff = (obs_q.size() == DB);
                for (int k = 0; k < obs_q.size(); k++)
                    if (obs_q[k][ch] == m_level[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) m_press[ch] = 1'b1;
                    else             m_release[ch] = 1'b1;
                end
                if (m_press[ch]) press_edge[ch] = m_cyc;
                m_d = m_cyc - press_edge[ch];
                m_strobe[ch] = m_level[ch] &&
                               ((m_d == 0) || ((m_d >= RD) && (((m_d - RD) % RR) == 0)));
            end
        end
    end

    // Single compare process, well after the active edge.
    always @(posedge clk) begin
        #3;
        if (check_en) begin
            check_vec("level",   btn_level,   m_level);
            check_vec("press",   btn_press,   m_press);
            check_vec("release", btn_release, m_release);
            check_vec("strobe",  btn_strobe,  m_strobe);
        end
    end

    // ---------------------------------------------------------------- event log
    typedef struct {
        int ch;
        int e;
        int kind;
    } ev_t;
    ev_t ev_q[$];

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int ch = 0; ch < N; ch++) begin
                if (btn_press[ch])   ev_q.push_back('{ch, tb_cyc, KP});
                if (btn_release[ch]) ev_q.push_back('{ch, tb_cyc, KR});
                if (btn_strobe[ch])  ev_q.push_back('{ch, tb_cyc, KS});
            end
        end
    end

    function automatic int find_ev(input int kind, input int ch, input int from);
        foreach (ev_q[i])
            if (ev_q[i].kind == kind && ev_q[i].ch == ch && ev_q[i].e >= from)
                return ev_q[i].e;
        return -1;
    endfunction

    function automatic int count_ev(input int kind, input int ch, input int from, input int upto);
        int n = 0;
        foreach (ev_q[i])
            if (ev_q[i].kind == kind && ev_q[i].ch == ch && ev_q[i].e >= from && ev_q[i].e <= upto)
                n++;
        return n;
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int e);
        while (tb_cyc < e) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    int c, p, p2, p3, p4;
    int hold [N];
    int glitch_levels;

    initial begin
        rst    = 1'b1;
        btn_in = '0;
        @(negedge clk);
        check_en = 1'b1;
        step(2);
        check_vec("reset_level",   btn_level,   '0);
        check_vec("reset_press",   btn_press,   '0);
        check_vec("reset_release", btn_release, '0);
        check_vec("reset_strobe",  btn_strobe,  '0);
        rst = 1'b0;
        step(5);

        // Clean press / release on channel 0
        c = tb_cyc;
        btn_in[0] = 1'b1;
        step(10);
        check_int("clean_press_edge",  find_ev(KP, 0, c), c + 6);
        check_int("clean_strobe_edge", find_ev(KS, 0, c), c + 6);
        check_int("clean_press_width", count_ev(KP, 0, c, tb_cyc), 1);
        check_int("clean_other_press", count_ev(KP, 1, c, tb_cyc) + count_ev(KP, 4, c, tb_cyc), 0);
        c = tb_cyc;
        btn_in[0] = 1'b0;
        step(10);
        check_int("clean_release_edge", find_ev(KR, 0, c), c + 6);

        // Glitch rejection on channel 1
        c = tb_cyc;
        btn_in[1] = 1'b1;
        step(3);
        btn_in[1] = 1'b0;
        glitch_levels = 0;
        repeat (12) begin
            @(negedge clk);
            if (btn_level[1]) glitch_levels++;
        end
        check_int("glitch_press",  count_ev(KP, 1, c, tb_cyc), 0);
        check_int("glitch_strobe", count_ev(KS, 1, c, tb_cyc), 0);
        check_int("glitch_level",  glitch_levels, 0);

        // Bounce 1,1,0,1,1,1,1 on channel 1
        btn_in[1] = 1'b1;
        step(2);
        btn_in[1] = 1'b0;
        step(1);
        c = tb_cyc;
        btn_in[1] = 1'b1;
        step(10);
        check_int("bounce_press_edge", find_ev(KP, 1, c - 4), c + 6);
        btn_in[1] = 1'b0;
        step(10);

        // Auto-repeat on channel 2
        c = tb_cyc;
        btn_in[2] = 1'b1;
        step(8);
        p = find_ev(KP, 2, c);
        check_int("rpt_press_edge", p, c + 6);
        wait_until(p + 36);
        btn_in[2] = 1'b0;
        step(12);
        check_int("rpt_strobe0", find_ev(KS, 2, p),      p);
        check_int("rpt_strobe1", find_ev(KS, 2, p + 1),  p + 20);
        check_int("rpt_strobe2", find_ev(KS, 2, p + 21), p + 28);
        check_int("rpt_strobe3", find_ev(KS, 2, p + 29), p + 36);
        check_int("rpt_no_strobe4", find_ev(KS, 2, p + 37), -1);
        check_int("rpt_release_edge", find_ev(KR, 2, p), p + 42);

        // Release colliding with the repeat strobe at P+28
        c = tb_cyc;
        btn_in[2] = 1'b1;
        step(8);
        p = find_ev(KP, 2, c);
        wait_until(p + 22);
        btn_in[2] = 1'b0;
        step(12);
        check_int("coll_release_edge", find_ev(KR, 2, p), p + 28);
        check_int("coll_strobe1",      find_ev(KS, 2, p + 1), p + 20);
        check_int("coll_no_strobe",    find_ev(KS, 2, p + 21), -1);
        c = tb_cyc;
        btn_in[2] = 1'b1;
        step(8);
        p2 = find_ev(KP, 2, c);
        check_int("repress_edge", p2, c + 6);
        wait_until(p2 + 24);
        check_int("repress_strobe1", find_ev(KS, 2, p2 + 1), p2 + 20);
        btn_in[2] = 1'b0;
        step(10);

        // Simultaneous press on channels 3 and 4
        c = tb_cyc;
        btn_in[4:3] = 2'b11;
        step(8);
        p3 = find_ev(KP, 3, c);
        p4 = find_ev(KP, 4, c);
        check_int("simul_press3", p3, c + 6);
        check_int("simul_press4", p4, c + 6);
        wait_until(p4 + 2);
        btn_in[3] = 1'b0;
        wait_until(p4 + 40);
        check_int("simul_release3", find_ev(KR, 3, p3), p4 + 8);
        check_int("simul_s4_1", find_ev(KS, 4, p4 + 1),  p4 + 20);
        check_int("simul_s4_2", find_ev(KS, 4, p4 + 21), p4 + 28);
        check_int("simul_s4_3", find_ev(KS, 4, p4 + 29), p4 + 36);
        check_int("simul_s3_none", count_ev(KS, 3, p3 + 1, tb_cyc), 0);
        btn_in[4] = 1'b0;
        step(10);

        // Reset while channel 0 is auto-repeating
        c = tb_cyc;
        btn_in[0] = 1'b1;
        step(8);
        p = find_ev(KP, 0, c);
        wait_until(p + 25);
        rst = 1'b1;
        #1;
        check_vec("rst_mid_level",   btn_level,   '0);
        check_vec("rst_mid_press",   btn_press,   '0);
        check_vec("rst_mid_release", btn_release, '0);
        check_vec("rst_mid_strobe",  btn_strobe,  '0);
        step(3);
        c = tb_cyc;
        rst = 1'b0;
        step(10);
        check_int("rst_repress_edge", find_ev(KP, 0, c), c + 6);
        btn_in[0] = 1'b0;
        step(10);

        // Randomized phase: each channel holds for a random duration, mostly
        // short (bounces/glitches), sometimes long enough to auto-repeat.
        for (int ch = 0; ch < N; ch++) hold[ch] = $urandom_range(1, 10);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500) rst = 1'b1;
            if (cyc == 1503) rst = 1'b0;
            for (int ch = 0; ch < N; ch++) begin
                if (hold[ch] == 0) begin
                    btn_in[ch] = ~btn_in[ch];
                    hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70)
                                                           : $urandom_range(1, 6);
                end else begin
                    hold[ch]--;
                end
            end
        end
        btn_in = '0;
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
